// File: rtl/prince_masked_pkg.sv
// Shared types and sizes for the masked PRINCE datapath blocks.
package prince_masked_pkg;

  localparam int NUM_SHARES   = 3;
  localparam int STATE_W      = 64;
  localparam int BYTE_W       = 8;
  localparam int BYTES        = 8;
  localparam int RND_PER_BYTE = 216;
  localparam int IDX_W        = $clog2(BYTES);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } seq_state_t;

  // Travels alongside each byte through the S-box pair so the result lands in the right lane.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  // Extracts byte lane k of a 64-bit share.
  function automatic logic [BYTE_W-1:0] state_byte(input logic [STATE_W-1:0] s,
                                                    input logic [IDX_W-1:0]   k);
    return s[{k, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/prince_sbox_layer_seq_byte_tag_pipe.sv
// Byte tag delay line matching the register latency of the masked S-box pair.
module byte_tag_pipe
  import prince_masked_pkg::*;
#(
  parameter int SBOX_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [SBOX_LAT];

  // Shift tags one stage per clock; reset drops every in-flight tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SBOX_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < SBOX_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[SBOX_LAT-1];

endmodule

// File: rtl/prince_sbox_layer_seq.sv
// Byte-serial sequencer for one masked PRINCE inverse S-box layer (3 shares).
// Optional build macro PRINCE_SEQ_ZEROIZE_EN clears the share registers once they are no longer needed.
module prince_sbox_layer_seq
  import prince_masked_pkg::*;
#(
  parameter int SBOX_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [STATE_W-1:0]      in_s1,
  input  logic [STATE_W-1:0]      in_s2,
  input  logic [STATE_W-1:0]      in_s3,
  input  logic                    rnd_valid,
  output logic                    rnd_ready,
  input  logic [RND_PER_BYTE-1:0] rnd,
  output logic [BYTE_W-1:0]       sbox_in1,
  output logic [BYTE_W-1:0]       sbox_in2,
  output logic [BYTE_W-1:0]       sbox_in3,
  output logic [RND_PER_BYTE-1:0] sbox_r,
  input  logic [BYTE_W-1:0]       sbox_out1,
  input  logic [BYTE_W-1:0]       sbox_out2,
  input  logic [BYTE_W-1:0]       sbox_out3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [STATE_W-1:0]      out_s1,
  output logic [STATE_W-1:0]      out_s2,
  output logic [STATE_W-1:0]      out_s3
);

  seq_state_t         state_q, state_d;
  logic [STATE_W-1:0] s1_q, s2_q, s3_q;
  logic [IDX_W-1:0]   k_q;
  logic               inject;
  logic               capture;
  tag_t               tag_push;
  tag_t               tag_out;
  logic [5:0]         cap_lsb;

  // Randomness is passed straight through; the pair only uses it when a real byte is injected.
  assign sbox_r = rnd;

  // A tag leaving the pipe marks the S-box output of that byte lane as valid right now.
  assign capture = tag_out.valid && ((state_q == FEED) || (state_q == DRAIN));
  assign cap_lsb = {tag_out.idx, 3'b000};

  byte_tag_pipe #(
    .SBOX_LAT (SBOX_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_push),
    .tag_out (tag_out)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake decode; bubbles and idle cycles drive the all-zero sharing.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    rnd_ready = 1'b0;
    out_valid = 1'b0;
    inject    = 1'b0;
    sbox_in1  = '0;
    sbox_in2  = '0;
    sbox_in3  = '0;
    tag_push  = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = FEED;
      end
      FEED: begin
        if (rnd_valid) begin
          inject         = 1'b1;
          rnd_ready      = 1'b1;
          sbox_in1       = state_byte(s1_q, k_q);
          sbox_in2       = state_byte(s2_q, k_q);
          sbox_in3       = state_byte(s3_q, k_q);
          tag_push.valid = 1'b1;
          tag_push.idx   = k_q;
          if (k_q == IDX_W'(BYTES - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (capture && (tag_out.idx == IDX_W'(BYTES - 1))) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Share latching, byte counter and per-lane result capture; shares stay in separate registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      k_q    <= '0;
      out_s1 <= '0;
      out_s2 <= '0;
      out_s3 <= '0;
    end else begin
      if ((state_q == IDLE) && in_valid) begin
        s1_q <= in_s1;
        s2_q <= in_s2;
        s3_q <= in_s3;
        k_q  <= '0;
      end
      if (inject) k_q <= k_q + IDX_W'(1);
`ifdef PRINCE_SEQ_ZEROIZE_EN
      if (inject && (k_q == IDX_W'(BYTES - 1))) begin
        s1_q <= '0;
        s2_q <= '0;
        s3_q <= '0;
      end
`endif
      if (capture) begin
        out_s1[cap_lsb +: BYTE_W] <= sbox_out1;
        out_s2[cap_lsb +: BYTE_W] <= sbox_out2;
        out_s3[cap_lsb +: BYTE_W] <= sbox_out3;
      end
`ifdef PRINCE_SEQ_ZEROIZE_EN
      if ((state_q == DONE) && out_ready) begin
        out_s1 <= '0;
        out_s2 <= '0;
        out_s3 <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_prince_sbox_layer_seq.sv
// Self-checking bench for prince_sbox_layer_seq with a behavioural masked S-box pair behind it.
module tb_prince_sbox_layer_seq;

  localparam int SBOX_LAT = 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_s1, in_s2, in_s3;
  logic         rnd_valid;
  logic         rnd_ready;
  logic [215:0] rnd;
  logic [7:0]   sbox_in1, sbox_in2, sbox_in3;
  logic [215:0] sbox_r;
  logic [7:0]   sbox_out1, sbox_out2, sbox_out3;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_s1, out_s2, out_s3;

  int checks = 0;
  int passes = 0;

  localparam logic [3:0] INV_SBOX [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                                           4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};

  typedef struct {
    logic [63:0] state;
    logic [31:0] bubbles;
    int          hold;
    bit          alt;
    logic [63:0] exp_xor;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  prince_sbox_layer_seq #(.SBOX_LAT(SBOX_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s1     (in_s1),
    .in_s2     (in_s2),
    .in_s3     (in_s3),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd       (rnd),
    .sbox_in1  (sbox_in1),
    .sbox_in2  (sbox_in2),
    .sbox_in3  (sbox_in3),
    .sbox_r    (sbox_r),
    .sbox_out1 (sbox_out1),
    .sbox_out2 (sbox_out2),
    .sbox_out3 (sbox_out3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s1    (out_s1),
    .out_s2    (out_s2),
    .out_s3    (out_s3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-layer reference: inverse S-box on every nibble of the unmasked state.
  function automatic logic [63:0] inv_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[n*4 +: 4] = INV_SBOX[x[n*4 +: 4]];
    return y;
  endfunction

  // Stand-in for the masked pair: correct sharing of S^-1(x), remasked with fresh bits, SBOX_LAT deep.
  function automatic logic [23:0] pair_model(input logic [7:0] a, b, c, input logic [215:0] r);
    logic [7:0] x, y;
    x = a ^ b ^ c;
    y = {INV_SBOX[x[7:4]], INV_SBOX[x[3:0]]};
    return {y ^ r[7:0] ^ r[15:8], r[7:0], r[15:8]};
  endfunction

  logic [23:0] pair_pipe [SBOX_LAT];

  always @(posedge clk) begin
    pair_pipe[0] <= pair_model(sbox_in1, sbox_in2, sbox_in3, sbox_r);
    for (int i = 1; i < SBOX_LAT; i++) pair_pipe[i] <= pair_pipe[i-1];
  end

  assign {sbox_out1, sbox_out2, sbox_out3} = pair_pipe[SBOX_LAT-1];

  function automatic logic [215:0] rand216();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom();
    return t[215:0];
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  // One full transaction: accept, feed with the vector's bubble pattern, check result, hold, handshake.
  task automatic apply_stimulus(input vec_t v);
    logic [63:0] snap1, snap2, snap3;
    int waitc, cyc, got, rr;
    waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check_output("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_s1    = {$urandom(), $urandom()};
    in_s2    = {$urandom(), $urandom()};
    in_s3    = v.state ^ in_s1 ^ in_s2;
    in_valid = 1'b1;
    @(posedge clk);
    cyc = 0;
    got = -1;
    rr  = 0;
    while (got < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      in_valid = v.alt;
      if (v.alt) begin
        in_s1 = {$urandom(), $urandom()};
        in_s2 = {$urandom(), $urandom()};
        in_s3 = {$urandom(), $urandom()};
      end
      rnd_valid = (cyc < 32) ? !v.bubbles[cyc] : 1'b1;
      rnd       = rand216();
      #1;
      if (rnd_ready) rr++;
      if (!rnd_valid) check_output("bubble_zero_shares", 64'({sbox_in1, sbox_in2, sbox_in3, rnd_ready}), 64'd0);
      if (out_valid) got = cyc;
    end
    in_valid  = 1'b0;
    rnd_valid = 1'b0;
    check_output("out_valid_cycle", 64'(got), 64'(v.exp_lat));
    check_output("result_xor", out_s1 ^ out_s2 ^ out_s3, v.exp_xor);
    check_output("rnd_ready_count", 64'(rr), 64'd8);
    snap1 = out_s1;
    snap2 = out_s2;
    snap3 = out_s3;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      #1;
      check_output("done_hold_valid_noready", 64'({out_valid, in_ready}), 64'b10);
      check_output("done_hold_s1", out_s1, snap1);
      check_output("done_hold_s2", out_s2, snap2);
      check_output("done_hold_s3", out_s3, snap3);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check_output("done_before_handshake", 64'({out_valid, in_ready}), 64'b10);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check_output("after_handshake_valid_ready", 64'({out_valid, in_ready}), 64'b01);
`ifdef PRINCE_SEQ_ZEROIZE_EN
    check_output("zeroized_out", out_s1 | out_s2 | out_s3, 64'd0);
`else
    check_output("retained_out", out_s1 ^ out_s2 ^ out_s3, v.exp_xor);
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] st;
    logic [31:0] m;
    vec_t rv;

    vecs[0] = '{64'h0123456789ABCDEF, 32'h0, 0, 1'b0, 64'hB732FD89A6405EC1, 11};
    vecs[1] = '{64'h0, (32'd1 << 3) | (32'd1 << 5), 2, 1'b0, 64'hBBBBBBBBBBBBBBBB, 13};
    for (int i = 2; i < 7; i++) begin
      st = {$urandom(), $urandom()};
      m  = (i == 2) ? 32'h0 : ($urandom() & 32'h1FE);
      vecs[i] = '{st, m, (i == 2) ? 5 : (i % 3), (i == 4), inv_layer(st), 9 + SBOX_LAT + $countones(m)};
    end

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_s1     = '0;
    in_s2     = '0;
    in_s3     = '0;
    rnd_valid = 1'b0;
    rnd       = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_output("reset_handshakes", 64'({in_ready, rnd_ready, out_valid}), 64'b100);
    check_output("reset_out_shares", out_s1 | out_s2 | out_s3, 64'd0);
    check_output("reset_sbox_in", 64'({sbox_in1, sbox_in2, sbox_in3}), 64'd0);
    rnd = rand216();
    #1;
    check_output("sbox_r_passthrough", 64'(sbox_r[63:0]), 64'(rnd[63:0]));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i]);

    // Reset in the middle of FEED with byte 4 on the S-box inputs.
    @(negedge clk);
    st        = {$urandom(), $urandom()};
    in_s1     = st;
    in_s2     = {$urandom(), $urandom()};
    in_s3     = {$urandom(), $urandom()};
    in_valid  = 1'b1;
    rnd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check_output("feed_byte4_share1", 64'(sbox_in1), 64'(st[39:32]));
    rst = 1'b1;
    #1;
    check_output("midreset_handshakes", 64'({in_ready, rnd_ready, out_valid}), 64'b100);
    check_output("midreset_out_cleared", out_s1 | out_s2 | out_s3, 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    rnd_valid = 1'b0;
    #1;
    check_output("after_reset_handshakes", 64'({in_ready, out_valid}), 64'b10);

    st = {$urandom(), $urandom()};
    rv = '{st, 32'h0, 0, 1'b0, inv_layer(st), 9 + SBOX_LAT};
    apply_stimulus(rv);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/prince_sbox_layer_seq.md
# prince_sbox_layer_seq

Byte-serial sequencer for one masked PRINCE inverse S-box layer. It accepts a 3-share 64-bit state and feeds it one byte per cycle into the externally instantiated second-order masked two-S-box pair. It also forwards the 216 fresh random bits that pair consumes per byte. It tracks each byte through the pair's pipeline and reassembles the 3-share 64-bit result for the downstream linear layer.

## Interface
- SBOX_LAT, 2: register latency of the S-box pair, from input byte to output byte (≥1).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input state offered.
- in_ready  out  1  sequencer can accept a state.
- in_s1, in_s2, in_s3  in  64 each  input state shares.
- rnd_valid  in  1  fresh randomness available this cycle.
- rnd_ready  out  1  randomness consumed this cycle.
- rnd  in  216  fresh randomness.
- sbox_in1, sbox_in2, sbox_in3  out  8 each  byte shares to the S-box pair.
- sbox_r  out  216  randomness to the S-box pair.
- sbox_out1, sbox_out2, sbox_out3  in  8 each  byte shares from the S-box pair.
- out_valid  out  1  result state valid.
- out_ready  in  1  downstream accepts the result.
- out_s1, out_s2, out_s3  out  64 each  result shares.

## Operation
- FSM states: IDLE, FEED, DRAIN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch all three shares, clear byte counter k, go to FEED.
- FEED:
  - Each cycle with rnd_valid=1 is an inject:
    - sbox_inN = in_sN[8k+7:8k]; sbox_r = rnd; rnd_ready=1.
    - Push tag {valid=1, idx=k} into a SBOX_LAT-deep tag pipe; k++.
  - Cycle with rnd_valid=0 is a bubble:
    - sbox_inN = 0 (a valid sharing of 0); sbox_r = rnd; rnd_ready=0.
    - Push an invalid tag.
  - After the inject with k=7, go to DRAIN.
- Tag pipe output valid with idx=j: capture sbox_outN into out_sN[8j+7:8j] at that clock edge. This applies in FEED and DRAIN.
- DRAIN:
  - Non-inject cycles only, with zero shares driven and rnd_ready=0.
  - Leave DRAIN when the last tag (idx=7) is captured; go to DONE.
- DONE:
  - out_valid=1; out_sN held stable.
  - On out_ready, go to IDLE. in_ready rises the following cycle, so there is no same-cycle turnaround.
- Shares are never XORed together inside this block. No combinational path exists from any in_sN share to another share's output.

## Timing
- Reset values:
  - in_ready=1, rnd_ready=0, out_valid=0.
  - out_s1..3=0, sbox_in1..3=0, tag pipe all invalid, k=0.
- sbox_inN and rnd_ready are combinational from state, k and rnd_valid. sbox_r = rnd at all times.
- With rnd_valid held at 1, for an accept at edge 0:
  - Injects occur in cycles 1..8.
  - out_valid rises in cycle 9+SBOX_LAT, which is cycle 11 for the default SBOX_LAT.
- Each rnd_valid=0 cycle during FEED adds exactly one cycle of latency.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Reset mid-operation: all state clears immediately and in-flight bytes are discarded. Tags are invalidated, so stale S-box pipeline outputs are never captured.

## Configuration
- Macro PRINCE_SEQ_ZEROIZE_EN:
  - Defined: the input share registers clear to 0 on the cycle after the k=7 inject. out_s1..3 clear to 0 on the cycle after the DONE handshake.
  - Undefined: registers retain their last values until overwritten.
  - Handshake timing is identical in both builds.

## Structure
- Shared package prince_masked_pkg holds:
  - NUM_SHARES=3, STATE_W=64, BYTE_W=8, BYTES=8, RND_PER_BYTE=216.
  - The FSM state enum.
  - The tag struct {valid, idx[2:0]}.
- One sub-module: byte_tag_pipe. This is a parameterised SBOX_LAT-stage shift register of tags with async reset.

## Test plan
The bench instantiates the masked S-box pair behind this block.
- Unmasked state 0x0123456789ABCDEF, random sharing, rnd_valid=1 throughout -> out_s1^out_s2^out_s3 = 0xB732FD89A6405EC1; out_valid in cycle 11.
- State 0 with rnd_valid low on cycles 3 and 5 -> XOR of outputs = 0xBBBBBBBBBBBBBBBB; out_valid in cycle 13; rnd_ready high exactly 8 cycles.
- out_ready held low for 5 cycles in DONE -> out_s1..3 stable; in_ready=0 until the cycle after the handshake; a second state then completes correctly.
- rst pulsed during FEED at k=4 -> in_ready=1, out_valid=0 next cycle; the following state's result is uncorrupted.
- in_valid asserted during FEED with a different state -> ignored; the result matches the first state.
- PRINCE_SEQ_ZEROIZE_EN defined -> out_s1..3 read 0 one cycle after the handshake; undefined -> values retained.
